// File: rtl/box_pyramid_pkg.sv
// Shared types and address-map helpers for the box-count pyramid generator.
package box_pyramid_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_GAP   = 3'd2,
    ST_FLUSH = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  function automatic int unsigned addr_w(input int unsigned box_idx);
    return 2 * box_idx + 1;
  endfunction

  function automatic int unsigned sat_max(input int unsigned data_len);
    return (32'd1 << data_len) - 32'd1;
  endfunction

  // Packed base of level k: every coarser level sits directly after the finer ones.
  function automatic int unsigned level_base(input int unsigned k, input int unsigned box_idx);
    int unsigned b;
    b = 0;
    for (int unsigned j = 0; j < box_idx; j++)
      if (j < k) b += 32'd1 << (2 * (box_idx - j));
    return b;
  endfunction

endpackage

// File: rtl/box_pyramid_addr_gen.sv
// Level/row/col/child counters and the read/write addresses they map to.
module box_pyramid_addr_gen
  import box_pyramid_pkg::*;
#(
  parameter int unsigned BOX_IDX = 3,
  parameter int unsigned LEVELS  = BOX_IDX
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         init,
  input  logic                         adv,
  input  logic                         next_lvl,
  input  logic                         clr,
  output logic [$clog2(BOX_IDX+1)-1:0] level,
  output logic [2*BOX_IDX:0]           rd_addr,
  output logic [2*BOX_IDX:0]           wr_addr,
  output logic [1:0]                   child,
  output logic                         last_cell,
  output logic                         last_level
);

  localparam int unsigned ADDR_W = addr_w(BOX_IDX);
  localparam int unsigned LW     = $clog2(BOX_IDX + 1);
  localparam logic [LW-1:0]      LVL_ONE = 1;
  localparam logic [BOX_IDX-1:0] RC_ONE  = 1;

  logic [BOX_IDX-1:0] row, col;
  logic [31:0] lv, sh, side_m1, rd_full, wr_full;

  always_comb begin
    lv      = 32'(level);
    sh      = BOX_IDX - lv;
    side_m1 = (32'd1 << sh) - 32'd1;
    // Child (2r+dy, 2c+dx) of the previous level, whose side is twice the current one.
    rd_full = level_base(lv - 32'd1, BOX_IDX)
            + (((32'(row) << 1) | 32'(child[1])) << (sh + 32'd1))
            + ((32'(col) << 1) | 32'(child[0]));
    wr_full = level_base(lv, BOX_IDX) + (32'(row) << sh) + 32'(col);
    rd_addr = rd_full[ADDR_W-1:0];
    wr_addr = wr_full[ADDR_W-1:0];
    last_cell  = (32'(row) == side_m1) && (32'(col) == side_m1) && (child == 2'd3);
    last_level = (lv == LEVELS);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      level <= '0;
      row   <= '0;
      col   <= '0;
      child <= '0;
    end else if (clr) begin
      level <= '0;
      row   <= '0;
      col   <= '0;
      child <= '0;
    end else if (init) begin
      level <= LVL_ONE;
      row   <= '0;
      col   <= '0;
      child <= '0;
    end else begin
      if (next_lvl) level <= level + LVL_ONE;
      if (adv) begin
        child <= child + 2'd1;
        if (child == 2'd3) begin
          if (32'(col) == side_m1) begin
            col <= '0;
            row <= (32'(row) == side_m1) ? '0 : row + RC_ONE;
          end else begin
            col <= col + RC_ONE;
          end
        end
      end
    end
  end

endmodule

// File: rtl/box_pyramid_gen.sv
// Builds coarser box-count levels as saturating 2x2 sums, written back into the same RAM.
module box_pyramid_gen
  import box_pyramid_pkg::*;
#(
  parameter int unsigned BOX_IDX  = 3,
  parameter int unsigned DATA_LEN = 12,
  parameter int unsigned LEVELS   = BOX_IDX
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         start,
  output logic                         rd_en,
  output logic [2*BOX_IDX:0]           rd_addr,
  input  logic [DATA_LEN-1:0]          rd_data,
  output logic                         wr_en,
  output logic [2*BOX_IDX:0]           wr_addr,
  output logic [DATA_LEN-1:0]          wr_data,
  output logic                         busy,
  output logic                         done,
  output logic [$clog2(BOX_IDX+1)-1:0] level,
  output logic                         sat_flag
);

  localparam int unsigned ADDR_W    = addr_w(BOX_IDX);
  localparam int unsigned SAT_MAX_I = sat_max(DATA_LEN);
  localparam logic [DATA_LEN+1:0] SAT_MAX = (DATA_LEN+2)'(SAT_MAX_I);

  state_t state, state_nx;
  logic gap_cnt;
  logic init, adv, next_lvl, clr;
  logic [ADDR_W-1:0] ag_rd_addr, ag_wr_addr, waddr1;
  logic [1:0] child, ch1;
  logic last_cell, last_level, v1;
  logic [DATA_LEN+1:0] acc, sum_c;
  logic clamp, wr_load;

  box_pyramid_addr_gen #(.BOX_IDX(BOX_IDX), .LEVELS(LEVELS)) u_addr (
    .CLK(CLK), .RST(RST), .init(init), .adv(adv), .next_lvl(next_lvl), .clr(clr),
    .level(level), .rd_addr(ag_rd_addr), .wr_addr(ag_wr_addr), .child(child),
    .last_cell(last_cell), .last_level(last_level)
  );

  always_comb begin
    state_nx = state;
    init     = 1'b0;
    adv      = 1'b0;
    next_lvl = 1'b0;
    clr      = 1'b0;
    case (state)
      ST_IDLE:  if (start) begin state_nx = ST_RUN; init = 1'b1; end
      ST_RUN: begin
        adv = 1'b1;
        if (last_cell) state_nx = last_level ? ST_FLUSH : ST_GAP;
      end
      ST_GAP:   if (gap_cnt) begin state_nx = ST_RUN; next_lvl = 1'b1; end
      // Only the last cell's write can still be pending here.
      ST_FLUSH: if (wr_en) state_nx = ST_DONE;
      ST_DONE:  begin state_nx = ST_IDLE; clr = 1'b1; end
      default:  state_nx = ST_IDLE;
    endcase
  end

  assign rd_en   = (state == ST_RUN);
  assign rd_addr = rd_en ? ag_rd_addr : '0;
  assign busy    = (state == ST_RUN) || (state == ST_GAP) || (state == ST_FLUSH);
  assign done    = (state == ST_DONE);

  always_comb begin
    sum_c   = ((ch1 == 2'd0) ? '0 : acc) + {2'b00, rd_data};
    clamp   = (sum_c > SAT_MAX);
    wr_load = v1 && (ch1 == 2'd3);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= ST_IDLE;
      gap_cnt  <= 1'b0;
      sat_flag <= 1'b0;
      v1       <= 1'b0;
      ch1      <= '0;
      waddr1   <= '0;
      acc      <= '0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
    end else begin
      state   <= state_nx;
      gap_cnt <= (state == ST_GAP) ? ~gap_cnt : 1'b0;
      if (init)                  sat_flag <= 1'b0;
      else if (wr_load && clamp) sat_flag <= 1'b1;
      v1     <= rd_en;
      ch1    <= child;
      waddr1 <= ag_wr_addr;
      if (v1) acc <= sum_c;
      wr_en <= wr_load;
      if (wr_load) begin
        wr_addr <= waddr1;
        wr_data <= clamp ? SAT_MAX[DATA_LEN-1:0] : sum_c[DATA_LEN-1:0];
      end
    end
  end

endmodule

// File: tb/tb_box_pyramid_gen.sv
// Self-checking bench: three parameterisations, each with its own behavioural RAM.
module tb_box_pyramid_gen;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  logic       st [3];
  logic       rd_en_v [3], wr_en_v [3], busy_v [3], done_v [3], sat_v [3];
  logic [6:0] rd_addr_v [3], wr_addr_v [3];
  logic [1:0] lvl_v [3];
  logic [11:0] wd0, wd2;
  logic [7:0]  wd1;
  logic [11:0] wdm [3];
  logic [11:0] rdd [3];
  logic [11:0] mem [3][128];

  always_comb begin
    wdm[0] = wd0;
    wdm[1] = {4'h0, wd1};
    wdm[2] = wd2;
  end

  box_pyramid_gen #(.BOX_IDX(3), .DATA_LEN(12), .LEVELS(3)) u_a (
    .CLK(CLK), .RST(RST), .start(st[0]), .rd_en(rd_en_v[0]), .rd_addr(rd_addr_v[0]),
    .rd_data(rdd[0]), .wr_en(wr_en_v[0]), .wr_addr(wr_addr_v[0]), .wr_data(wd0),
    .busy(busy_v[0]), .done(done_v[0]), .level(lvl_v[0]), .sat_flag(sat_v[0]));

  box_pyramid_gen #(.BOX_IDX(3), .DATA_LEN(8), .LEVELS(3)) u_b (
    .CLK(CLK), .RST(RST), .start(st[1]), .rd_en(rd_en_v[1]), .rd_addr(rd_addr_v[1]),
    .rd_data(rdd[1][7:0]), .wr_en(wr_en_v[1]), .wr_addr(wr_addr_v[1]), .wr_data(wd1),
    .busy(busy_v[1]), .done(done_v[1]), .level(lvl_v[1]), .sat_flag(sat_v[1]));

  box_pyramid_gen #(.BOX_IDX(3), .DATA_LEN(12), .LEVELS(1)) u_c (
    .CLK(CLK), .RST(RST), .start(st[2]), .rd_en(rd_en_v[2]), .rd_addr(rd_addr_v[2]),
    .rd_data(rdd[2]), .wr_en(wr_en_v[2]), .wr_addr(wr_addr_v[2]), .wr_data(wd2),
    .busy(busy_v[2]), .done(done_v[2]), .level(lvl_v[2]), .sat_flag(sat_v[2]));

  function automatic int pat_val(input int pat, input int a);
    case (pat)
      0: return 1;
      1: return a;
      2: return 100;
      default: return 0;
    endcase
  endfunction

  logic ld_req = 1'b0;
  int   ld_i = 0, ld_pat = 0;

  always @(posedge CLK) begin
    for (int i = 0; i < 3; i++) begin
      if (ld_req && ld_i == i) begin
        for (int a = 0; a < 128; a++)
          mem[i][a] <= (a < 64) ? 12'(pat_val(ld_pat, a)) : 12'hABC;
      end else if (wr_en_v[i]) begin
        mem[i][wr_addr_v[i]] <= wdm[i];
      end
      if (rd_en_v[i]) rdd[i] <= mem[i][rd_addr_v[i]];
    end
  end

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  typedef struct packed { logic [6:0] a; logic [11:0] d; } wr_t;
  wr_t sbq[$];

  typedef struct {
    int   inst;
    int   pat;
    int   extra;     // relative cycle of a stray start pulse, 0 = none
    int   first_rd;
    int   last_rd;
    int   nrd;
    int   last_wr;
    int   done_c;
    int   nwr;
    logic sat;
  } case_t;

  case_t tbl[5];
  logic [6:0] a4g [4];

  // Independent pyramid model using the known BOX_IDX=3 bases.
  task automatic build_exp(input int inst, input int pat);
    int m[128];
    int bs[4];
    int lv, mx, sk, sp, p, sum, v;
    bs = '{0, 64, 80, 84};
    lv = (inst == 2) ? 1 : 3;
    mx = (inst == 1) ? 255 : 4095;
    for (int a = 0; a < 64; a++) m[a] = pat_val(pat, a);
    for (int k = 1; k <= lv; k++) begin
      sk = 8 >> k;
      sp = 8 >> (k - 1);
      for (int r = 0; r < sk; r++)
        for (int c = 0; c < sk; c++) begin
          p = bs[k-1] + 2 * r * sp + 2 * c;
          sum = m[p] + m[p+1] + m[p+sp] + m[p+sp+1];
          v = (sum > mx) ? mx : sum;
          m[bs[k] + r * sk + c] = v;
          sbq.push_back({7'(bs[k] + r * sk + c), 12'(v)});
        end
    end
  endtask

  task automatic run_case(input case_t t);
    int i, s, rel, first_rd, last_rd, nrd, last_wr, done_c, nwr, exp_lvl;
    bit fin;
    wr_t e;
    i = t.inst;
    first_rd = -1; last_rd = -1; nrd = 0; last_wr = -1; done_c = -1; nwr = 0; fin = 0;
    @(negedge CLK);
    ld_i = i; ld_pat = t.pat; ld_req = 1'b1;
    @(negedge CLK);
    ld_req = 1'b0;
    sbq.delete();
    build_exp(i, t.pat);
    st[i] = 1'b1;
    s = cyc;
    for (int n = 0; n < 400 && !fin; n++) begin
      @(negedge CLK);
      rel = cyc - s;
      st[i] = (t.extra != 0 && rel == t.extra);
      if (rel == 1) begin
        chk("busy_c1", 32'(busy_v[i]), 1);
        chk("sat_clear_c1", 32'(sat_v[i]), 0);
      end
      if (rd_en_v[i]) begin
        if (first_rd < 0) first_rd = rel;
        if (nrd < 4) a4g[nrd] = rd_addr_v[i];
        exp_lvl = (nrd < 64) ? 1 : ((nrd < 80) ? 2 : 3);
        chk("level_run", 32'(lvl_v[i]), exp_lvl);
        nrd++;
        last_rd = rel;
      end
      if (wr_en_v[i]) begin
        nwr++;
        last_wr = rel;
        if (sbq.size() == 0) chk("wr_unexpected", 32'(nwr), 0);
        else begin
          e = sbq.pop_front();
          chk("wr_addr", 32'(wr_addr_v[i]), 32'(e.a));
          chk("wr_data", 32'(wdm[i]), 32'(e.d));
        end
      end
      if (done_v[i]) begin
        done_c = rel;
        chk("busy_at_done", 32'(busy_v[i]), 0);
        fin = 1;
      end
    end
    chk("done_seen", 32'(fin), 1);
    @(negedge CLK);
    st[i] = 1'b0;
    chk("first_rd", first_rd, t.first_rd);
    chk("last_rd", last_rd, t.last_rd);
    chk("n_rd", nrd, t.nrd);
    chk("last_wr", last_wr, t.last_wr);
    chk("done_cyc", done_c, t.done_c);
    chk("n_wr", nwr, t.nwr);
    chk("sat_flag", 32'(sat_v[i]), 32'(t.sat));
    chk("sb_left", sbq.size(), 0);
    chk("idle_level", 32'(lvl_v[i]), 0);
    chk("idle_busy", 32'(busy_v[i]), 0);
    chk("idle_rd_en", 32'(rd_en_v[i]), 0);
  endtask

  initial begin
    int s, rel, pre_wr, post_act;
    tbl[0] = '{0, 0, 0,  1, 88, 84, 90, 91, 21, 1'b0};
    tbl[1] = '{0, 1, 20, 1, 88, 84, 90, 91, 21, 1'b0};
    tbl[2] = '{1, 2, 0,  1, 88, 84, 90, 91, 21, 1'b1};
    tbl[3] = '{1, 3, 91, 1, 88, 84, 90, 91, 21, 1'b0};
    tbl[4] = '{2, 0, 0,  1, 64, 64, 66, 67, 16, 1'b0};
    for (int i = 0; i < 3; i++) st[i] = 1'b0;

    RST = 1'b1;
    repeat (3) @(negedge CLK);
    for (int i = 0; i < 3; i++) begin
      chk("rst_rd_en", 32'(rd_en_v[i]), 0);
      chk("rst_wr_en", 32'(wr_en_v[i]), 0);
      chk("rst_busy", 32'(busy_v[i]), 0);
      chk("rst_done", 32'(done_v[i]), 0);
      chk("rst_level", 32'(lvl_v[i]), 0);
      chk("rst_sat", 32'(sat_v[i]), 0);
    end
    RST = 1'b0;

    for (int t = 0; t < 5; t++) begin
      run_case(tbl[t]);
      if (t == 1) begin
        chk("rd_seq0", 32'(a4g[0]), 0);
        chk("rd_seq1", 32'(a4g[1]), 1);
        chk("rd_seq2", 32'(a4g[2]), 8);
        chk("rd_seq3", 32'(a4g[3]), 9);
        chk("mem64", 32'(mem[0][64]), 18);
        chk("mem79", 32'(mem[0][79]), 234);
      end
      if (t == 4)
        for (int a = 80; a < 85; a++) chk("l1_untouched", 32'(mem[2][a]), 32'h0ABC);
    end

    // Reset in the middle of level 1 aborts all RAM traffic.
    @(negedge CLK);
    st[0] = 1'b1;
    s = cyc;
    pre_wr = 0;
    rel = 0;
    while (rel < 40) begin
      @(negedge CLK);
      st[0] = 1'b0;
      rel = cyc - s;
      if (wr_en_v[0]) pre_wr++;
    end
    chk("pre_rst_writes", pre_wr, 9);
    RST = 1'b1;
    @(negedge CLK);
    chk("abort_rd_en", 32'(rd_en_v[0]), 0);
    chk("abort_rd_addr", 32'(rd_addr_v[0]), 0);
    chk("abort_wr_en", 32'(wr_en_v[0]), 0);
    chk("abort_wr_addr", 32'(wr_addr_v[0]), 0);
    chk("abort_wr_data", 32'(wd0), 0);
    chk("abort_busy", 32'(busy_v[0]), 0);
    chk("abort_done", 32'(done_v[0]), 0);
    chk("abort_level", 32'(lvl_v[0]), 0);
    chk("abort_sat", 32'(sat_v[0]), 0);
    RST = 1'b0;
    post_act = 0;
    repeat (30) begin
      @(negedge CLK);
      if (wr_en_v[0] || rd_en_v[0] || busy_v[0]) post_act++;
    end
    chk("post_rst_activity", post_act, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/box_pyramid_gen.md
Name: box_pyramid_gen

Overview:
- Parametrised successor to the fixed three-level 2x2 box-sum generator in the MFA box-counting datapath.
- Starts from a level-0 box-count grid of side 2^BOX_IDX held in the box-count RAM. Builds LEVELS coarser levels, each cell being the saturating sum of its four children.
- Each level is written back into the same RAM at a packed base offset, for the downstream partition-function stage.
- Adds a start/busy/done handshake, generic level count, level hazard gaps and overflow saturation.

Parameters:
BOX_IDX, 3, log2 of level-0 grid side; legal 2..8
DATA_LEN, 12, width of every stored count
LEVELS, BOX_IDX, number of coarsening levels produced; legal 1..BOX_IDX

Ports:
CLK  in  1  clock
RST  in  1  asynchronous active-high reset
start  in  1  one-cycle request; honoured only in IDLE
rd_en  out  1  RAM read strobe
rd_addr  out  2*BOX_IDX+1  RAM read address
rd_data  in  DATA_LEN  RAM read data, valid exactly 1 cycle after rd_en
wr_en  out  1  RAM write strobe
wr_addr  out  2*BOX_IDX+1  RAM write address
wr_data  out  DATA_LEN  RAM write data
busy  out  1  high from cycle after accepted start until done
done  out  1  one-cycle pulse after final write
level  out  clog2(BOX_IDX+1)  level currently being produced (1..LEVELS); 0 in IDLE
sat_flag  out  1  sticky: some sum saturated since last accepted start

Behaviour:
- Reset: all outputs 0, FSM in IDLE, counters 0. RST mid-operation aborts immediately; no further reads or writes.
- Address map:
  - Level k has side S(k)=2^(BOX_IDX-k) and base B(k)=sum over j<k of 4^(BOX_IDX-j), with B(0)=0.
  - Cell (r,c) of level k is at B(k)+r*S(k)+c.
  - Example, BOX_IDX=3: bases 0, 64, 80, 84.
- FSM states:
  - IDLE: start goes to RUN, clears sat_flag, sets level=1.
  - RUN: issues one read per cycle.
  - GAP: 2 bubble cycles between levels, so the final write of level k-1 lands before level k reads it.
  - FLUSH: waits for the last write.
  - DONE: 1 cycle, done=1, then IDLE.
- Read order:
  - Output cells are visited in raster order (row-major).
  - Per output cell (r,c) of level k, four consecutive reads from level k-1: (2r,2c), (2r,2c+1), (2r+1,2c), (2r+1,2c+1).
  - rd_en stays high every RUN cycle, giving one output per 4 cycles.
- Datapath:
  - Reads for a cell are issued in cycles c..c+3; data returns in c+1..c+4.
  - The accumulator is DATA_LEN+2 bits, cleared on the first child.
  - wr_en=1 in cycle c+5 with wr_addr = B(k)+r*S(k)+col and wr_data = min(sum, 2^DATA_LEN-1).
  - Any clamp sets sat_flag.
- Level transition: after the last read of level k, if k<LEVELS go to GAP (2 cycles), then RUN with level=k+1; otherwise go to FLUSH.
- Completion:
  - done pulses the cycle after the final wr_en; busy drops in that same cycle.
  - rd_en=0 and wr_en=0 outside RUN/GAP/FLUSH except pending writes.
- start while busy is ignored. A start in the DONE cycle is ignored.
- Level-0 is never written.

Decomposition:
- Package box_pyramid_pkg:
  - FSM state enum (IDLE, RUN, GAP, FLUSH, DONE).
  - Constant function level_base(k, BOX_IDX).
  - ADDR_W = 2*BOX_IDX+1.
  - SAT_MAX constant.
- Sub-module box_pyramid_addr_gen: level/row/col/child counters producing rd_addr, the next write address and last-cell/last-level flags.
- The top module holds the FSM, accumulator, saturation and write register.

Test Plan:
- BOX_IDX=3, DATA_LEN=12, level 0 all 1s, start at cycle 0:
  - rd_en first in cycle 1.
  - Level 1 (addr 64..79) all 4; level 2 (80..83) all 16; level 3 (84) = 64.
  - Last wr_en in cycle 90; done in cycle 91; sat_flag=0.
- Level-0 cell value = its address (0..63):
  - Addr 64 = 0+1+8+9 = 18; addr 79 = 54+55+62+63 = 234.
  - Check the read-address sequence for cell 0 is 0, 1, 8, 9.
- DATA_LEN=8, level 0 all 100:
  - Level 1 all 255; sat_flag=1.
  - Next start with all-0 grid clears sat_flag and writes 0s.
- LEVELS=1: only addrs 64..79 written; no GAP cycles; done in cycle 67.
- Hazard check: assert RST in cycle 40 → all outputs 0 next cycle, no writes afterwards. A start pulse during busy (cycle 20) leaves the write count at 21.
